// File: rtl/spi_fill_rect_pkg.sv
// rtl/spi_fill_rect_pkg.sv - shared command constants, state encoding and coordinate type
package spi_fill_rect_pkg;

   localparam logic [7:0] CMD_CASET_DEF = 8'h2A;
   localparam logic [7:0] CMD_PASET_DEF = 8'h2B;
   localparam logic [7:0] CMD_RAMWR_DEF = 8'h2C;

   typedef logic [8:0] coord_t;

   typedef enum logic [3:0] {
      IDLE,
      CHECK,
      CASET_C,
      CASET_D,
      PASET_C,
      PASET_D,
      RAMWR_C,
      PIXELS,
      NEXT_BAND,
      FIN
   } state_t;

   // Address bytes go out as a 16-bit big-endian value; only bit 8 lands in the high byte.
   function automatic logic [7:0] coord_hi(input coord_t c);
      return {7'b0, c[8]};
   endfunction

   function automatic logic [7:0] coord_lo(input coord_t c);
      return c[7:0];
   endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// rtl/spi_byte_tx.sv - serialises one byte MSB first with chip select framing
module spi_byte_tx (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_byte,
   input  logic       i_we,
   output logic       o_mosi,
   output logic       o_cs,
   output logic       o_done
);

   // Bit 7 is driven straight from i_byte at load, so only the lower seven bits need storing.
   logic [6:0] shreg;
   logic [2:0] bit_cnt;
   logic       active;

   // Load on strobe, shift one bit per clock, release chip select and pulse done after bit 0.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
         active  <= 1'b0;
         o_mosi  <= 1'b0;
         o_cs    <= 1'b1;
         o_done  <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (active) begin
            if (bit_cnt == 3'd7) begin
               active <= 1'b0;
               o_cs   <= 1'b1;
               o_mosi <= 1'b0;
               o_done <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 3'd1;
               shreg   <= {shreg[5:0], 1'b0};
               o_mosi  <= shreg[6];
            end
         end else if (i_we) begin
            active  <= 1'b1;
            o_cs    <= 1'b0;
            shreg   <= i_byte[6:0];
            o_mosi  <= i_byte[7];
            bit_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/spi_fill_rect.sv
// rtl/spi_fill_rect.sv - fills a clipped panel rectangle with one colour, band by band
module spi_fill_rect
   import spi_fill_rect_pkg::*;
#(
   parameter int         WIDTH      = 240,
   parameter int         HEIGHT     = 320,
   parameter int         BAND_LINES = 8,
   parameter logic [7:0] CMD_CASET  = CMD_CASET_DEF,
   parameter logic [7:0] CMD_PASET  = CMD_PASET_DEF,
   parameter logic [7:0] CMD_RAMWR  = CMD_RAMWR_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [8:0]  i_x0,
   input  logic [8:0]  i_x1,
   input  logic [8:0]  i_y0,
   input  logic [8:0]  i_y1,
   input  logic [15:0] i_color,
   input  logic        i_abort,
   output logic        o_mosi,
   output logic        o_dc,
   output logic        o_cs,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);

   // Byte counter covers the largest band of pixel bytes.
   localparam int     PCW   = $clog2(WIDTH * BAND_LINES * 2 + 1);
   localparam coord_t X_MAX = coord_t'(WIDTH - 1);
   localparam coord_t Y_MAX = coord_t'(HEIGHT - 1);

   state_t         state, state_n, adv_state;
   coord_t         x0, x1, y1, yb, ye;
   logic [15:0]    color;
   logic           err_flag;
   logic           in_flight;
   logic [PCW-1:0] idx;
   logic [PCW-1:0] band_bytes;

   logic [9:0]     ye_ext, y1_ext, span_x, span_y;
   logic [19:0]    pix_prod;
   logic           last_band, empty;

   logic           is_tx, tx_we, tx_done, last_byte, byte_dc;
   logic [7:0]     tx_byte;

   // Band end is formed in 10 bits so yb + BAND_LINES - 1 cannot wrap before the clamp.
   assign y1_ext     = {1'b0, y1};
   assign ye_ext     = {1'b0, yb} + 10'(BAND_LINES - 1);
   assign ye         = (ye_ext > y1_ext) ? y1 : ye_ext[8:0];
   assign last_band  = (ye_ext >= y1_ext);
   assign span_x     = {1'b0, x1} - {1'b0, x0} + 10'd1;
   assign span_y     = {1'b0, ye} - {1'b0, yb} + 10'd1;
   assign pix_prod   = span_x * span_y;
   assign band_bytes = PCW'({pix_prod, 1'b0});
   assign empty      = (x0 > x1) || (yb > y1);

   assign o_busy = (state != IDLE) && (state != FIN);
   assign o_done = (state == FIN);
   assign o_err  = (state == FIN) && err_flag;

   spi_byte_tx u_tx (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_byte (tx_byte),
      .i_we   (tx_we),
      .o_mosi (o_mosi),
      .o_cs   (o_cs),
      .o_done (tx_done)
   );

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state, byte selection and transmit strobe; a byte state moves on only at byte done.
   always_comb begin
      state_n   = state;
      adv_state = state;
      is_tx     = 1'b0;
      tx_byte   = 8'h00;
      byte_dc   = 1'b0;
      last_byte = 1'b0;
      case (state)
         IDLE:      if (i_start) state_n = CHECK;
         CHECK:     state_n = empty ? FIN : CASET_C;
         CASET_C: begin
            is_tx     = 1'b1;
            tx_byte   = CMD_CASET;
            last_byte = 1'b1;
            adv_state = CASET_D;
         end
         CASET_D: begin
            is_tx   = 1'b1;
            byte_dc = 1'b1;
            case (idx[1:0])
               2'd0:    tx_byte = coord_hi(x0);
               2'd1:    tx_byte = coord_lo(x0);
               2'd2:    tx_byte = coord_hi(x1);
               default: tx_byte = coord_lo(x1);
            endcase
            last_byte = (idx == PCW'(3));
            adv_state = PASET_C;
         end
         PASET_C: begin
            is_tx     = 1'b1;
            tx_byte   = CMD_PASET;
            last_byte = 1'b1;
            adv_state = PASET_D;
         end
         PASET_D: begin
            is_tx   = 1'b1;
            byte_dc = 1'b1;
            case (idx[1:0])
               2'd0:    tx_byte = coord_hi(yb);
               2'd1:    tx_byte = coord_lo(yb);
               2'd2:    tx_byte = coord_hi(ye);
               default: tx_byte = coord_lo(ye);
            endcase
            last_byte = (idx == PCW'(3));
            adv_state = RAMWR_C;
         end
         RAMWR_C: begin
            is_tx     = 1'b1;
            tx_byte   = CMD_RAMWR;
            last_byte = 1'b1;
            adv_state = PIXELS;
         end
         PIXELS: begin
            is_tx     = 1'b1;
            byte_dc   = 1'b1;
            tx_byte   = idx[0] ? color[7:0] : color[15:8];
            last_byte = (idx == band_bytes - PCW'(1));
            // The final band finishes straight away so done follows the last byte by one cycle.
            adv_state = last_band ? FIN : NEXT_BAND;
         end
         NEXT_BAND: state_n = (({1'b0, yb} + 10'(BAND_LINES)) > y1_ext) ? FIN : CASET_C;
         FIN:       state_n = IDLE;
         default:   state_n = IDLE;
      endcase
      if (is_tx && tx_done) begin
         if (i_abort) begin
            state_n = FIN;
         end else if (last_byte) begin
            state_n = adv_state;
         end
      end
   end

   assign tx_we = is_tx && !in_flight;

   // Operation registers: capture with clamp, byte counter, band row, error flag and dc.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         x0        <= '0;
         x1        <= '0;
         y1        <= '0;
         yb        <= '0;
         color     <= '0;
         err_flag  <= 1'b0;
         in_flight <= 1'b0;
         idx       <= '0;
         o_dc      <= 1'b0;
      end else begin
         if (state == IDLE && i_start) begin
            x0       <= i_x0;
            x1       <= (i_x1 > X_MAX) ? X_MAX : i_x1;
            yb       <= i_y0;
            y1       <= (i_y1 > Y_MAX) ? Y_MAX : i_y1;
            color    <= i_color;
            err_flag <= 1'b0;
         end
         if (state == CHECK && empty) begin
            err_flag <= 1'b1;
         end
         if (is_tx && tx_done && i_abort) begin
            err_flag <= 1'b1;
         end
         if (tx_we) begin
            in_flight <= 1'b1;
            o_dc      <= byte_dc;
         end
         if (tx_done) begin
            in_flight <= 1'b0;
            idx       <= (state_n != state) ? '0 : idx + PCW'(1);
         end
         if (state == NEXT_BAND) begin
            yb <= yb + coord_t'(BAND_LINES);
         end
      end
   end

endmodule

// File: doc/spi_fill_rect.md
SPI_FILL_RECT -- requirements
Module: spi_fill_rect

Interface
REQ-001 Parameters (name, default, meaning):
- WIDTH, 240, panel columns.
- HEIGHT, 320, panel rows.
- BAND_LINES, 8, rows per window band; range 1..HEIGHT.
- CMD_CASET, 8'h2A, column-address command.
- CMD_PASET, 8'h2B, page-address command.
- CMD_RAMWR, 8'h2C, memory-write command.

REQ-002 Ports (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_rst, in, 1, reset; asynchronous, active-high.
- i_start, in, 1, start request; accepted only in IDLE.
- i_x0, i_x1, in, 9 each, inclusive column bounds.
- i_y0, i_y1, in, 9 each, inclusive row bounds.
- i_color, in, 16, RGB565 fill colour.
- i_abort, in, 1, stop request, honoured at the next byte boundary.
- o_mosi, out, 1, serial data, MSB first.
- o_dc, out, 1, 0 = command byte, 1 = data byte.
- o_cs, out, 1, chip select, active low.
- o_busy, out, 1, operation in progress.
- o_done, out, 1, one-cycle completion pulse.
- o_err, out, 1, one-cycle pulse with o_done on an empty window or an abort.

Function
REQ-003 Capture: when i_start is high in IDLE, all coordinates and i_color are captured; i_start is ignored while o_busy is high.
REQ-004 o_busy timing: rises the cycle after start is accepted; falls in the same cycle o_done pulses.
REQ-005 Clipping: x1 is clamped to min(i_x1, WIDTH-1); y1 is clamped to min(i_y1, HEIGHT-1).
REQ-006 Empty window: if x0>x1 or y0>y1 after clamping, no bytes are sent and o_done and o_err pulse 2 cycles after start.
REQ-007 Band addressing: each band starts at row yb (initially y0) and ends at ye = min(yb+BAND_LINES-1, y1).
REQ-008 Per-band byte order:
- CASET, then x0 hi, x0 lo, x1 hi, x1 lo.
- PASET, then yb hi, yb lo, ye hi, ye lo.
- RAMWR, then (x1-x0+1)*(ye-yb+1) pixels, each sent as colour hi byte then colour lo byte.
REQ-009 Band advance: after each band, yb += BAND_LINES; the operation completes when yb > y1.
REQ-010 Completion: o_done pulses one cycle after the final byte's done; o_err stays 0.
REQ-011 State machine states: IDLE, CHECK, CASET_C, CASET_D, PASET_C, PASET_D, RAMWR_C, PIXELS, NEXT_BAND, FIN.
- IDLE->CHECK on start.
- CHECK->FIN if empty, else CASET_C.
- Within a band, each state advances on byte done when its byte count is exhausted.
- NEXT_BAND->CASET_C or FIN.
- FIN->IDLE.
REQ-012 Byte handshake: the byte transmitter gets a one-cycle write strobe; the next strobe is issued no earlier than the cycle after that byte's done pulse.
REQ-013 o_dc: changes only between bytes, and is stable while o_cs is low.
REQ-014 Abort: i_abort is sampled at each byte done.
- If high, no further bytes are sent and FIN is entered.
- o_done and o_err pulse together.
- An abort in IDLE is ignored.
REQ-015 Arithmetic widths:
- Coordinates are 9 bits.
- The pixel counter is wide enough for WIDTH*BAND_LINES*2 bytes.
- ye is computed in 10 bits before the min, so yb+BAND_LINES never wraps.
REQ-016 Byte transmitter timing:
- Shifts 8 bits MSB first, one bit per i_clk.
- o_cs is low for exactly those 8 cycles.
- Its done pulse arrives 9 cycles after the strobe.
- Back-to-back bytes leave o_cs high for at least 1 cycle between them.
REQ-017 Simultaneous start and abort in IDLE: start is accepted and the abort is ignored.

Reset
REQ-018 On i_rst, all outputs take these values immediately, mid-byte included:
- o_cs=1, o_mosi=0, o_dc=0.
- o_busy=0, o_done=0, o_err=0.
REQ-019 On i_rst, the state returns to IDLE and all counters and captured registers clear to 0.
REQ-020 After reset release, the first accepted start behaves as a fresh operation; there is no resumption.

Structure
REQ-021 A shared package holds the command constants, the state encoding, and the 9-bit coordinate type.
REQ-022 Byte serialisation lives in one sub-module, spi_byte_tx, with ports:
- inputs i_clk, i_rst, i_byte[7:0], i_we;
- outputs o_mosi, o_cs, o_done.
- spi_fill_rect owns o_dc.

Verification
REQ-023 Single pixel: start with (10,20)-(10,20), colour 16'hF800 -> bytes 2A 00 0A 00 0A 2B 00 14 00 14 2C F8 00 with dc 0,1,1,1,1,0,1,1,1,1,0,1,1; one o_done pulse, o_err=0.
REQ-024 Band split: (0,0)-(1,9), BAND_LINES=8 -> two bands.
- First band: PASET data 00 00 00 07, 32 pixel bytes.
- Second band: PASET data 00 08 00 09, 8 pixel bytes.
REQ-025 Clipping: x1=500, y1=400 -> CASET data ends 00 EF, PASET ends 01 3F; total pixel bytes 240*320*2=153600.
REQ-026 Empty window: x0=5, x1=4 -> no o_cs low at all; o_done and o_err pulse 2 cycles after start.
REQ-027 Abort: i_abort raised during PIXELS -> current byte completes, o_cs returns high, o_done+o_err pulse, o_busy falls.
REQ-028 Reset and start-while-busy:
- i_rst asserted mid-byte -> o_cs=1 and o_busy=0 in the same cycle.
- i_start pulsed while busy -> byte stream unchanged.
